// File: rtl/ram16k_arbiter.sv
// ram16k_arbiter: fixed-priority two-port arbiter in front of ram16k, with a starvation override for port 1
//   params : ADDR_W address width, DATA_W data width, STARVE_MAX denied cycles before port 1 wins (1..15)
//   clk, rst_n                      : clock, asynchronous active-low reset
//   pN_req/we/addr/wdata            : port N request, write enable, word address, write data
//   pN_gnt                          : combinational grant, access happens at this cycle's rising edge
//   pN_rvalid/rdata                 : registered read response, one cycle after a read grant
//   ram_load/address/data_in        : drive to ram16k
//   ram_data_out                    : combinational read data from ram16k
module ram16k_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] wait_cnt;
    logic       sel1;
    // rst_n gates the grants so nothing is written while reset is held
    always_comb begin
        sel1        = rst_n & p1_req & (~p0_req | (wait_cnt == SMAX));
        p1_gnt      = sel1;
        p0_gnt      = rst_n & p0_req & ~sel1;
        ram_address = sel1 ? p1_addr : p0_addr;
        ram_data_in = sel1 ? p1_wdata : p0_wdata;
        ram_load    = (p0_gnt & p0_we) | (p1_gnt & p1_we);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            wait_cnt  <= (p1_gnt | ~p1_req) ? 4'd0 : (wait_cnt == SMAX) ? wait_cnt : wait_cnt + 4'd1;
            p0_rvalid <= p0_gnt & ~p0_we;
            p1_rvalid <= p1_gnt & ~p1_we;
            if (p0_gnt & ~p0_we) p0_rdata <= ram_data_out;
            if (p1_gnt & ~p1_we) p1_rdata <= ram_data_out;
        end
    end
endmodule

// File: tb/tb_ram16k_arbiter.sv
// tb_ram16k_arbiter: directed bench with a ram16k stand-in, a per-cycle behavioural model and literal checks
module tb_ram16k_arbiter;
    localparam int SM = 4;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [13:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [15:0] p0_rdata, p1_rdata;
    logic        ram_load;
    logic [13:0] ram_address;
    logic [15:0] ram_data_in, ram_data_out;
    logic [15:0] mem     [0:16383];
    logic [15:0] ref_mem [0:16383];
    int          total = 0, passed = 0;

    ram16k_arbiter #(.ADDR_W(14), .DATA_W(16), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_load(ram_load), .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    assign ram_data_out = mem[ram_address];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_data_in;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    endtask

    // Model: port 1 wins when port 0 is idle or once it has been refused SM cycles in a row
    int          denied = 0;
    logic        m_rv0 = 0, m_rv1 = 0;
    logic [15:0] m_rd0 = 0, m_rd1 = 0;
    always @(negedge clk) begin
        logic w1, g0, ld;
        if (!rst_n) begin
            chk("rst_p0_gnt", p0_gnt, 0);
            chk("rst_p1_gnt", p1_gnt, 0);
            chk("rst_load", ram_load, 0);
            chk("rst_p0_rv", p0_rvalid, 0);
            chk("rst_p1_rv", p1_rvalid, 0);
            chk("rst_p0_rd", p0_rdata, 0);
            chk("rst_p1_rd", p1_rdata, 0);
            denied = 0; m_rv0 = 0; m_rv1 = 0; m_rd0 = 0; m_rd1 = 0;
        end else begin
            chk("m_p0_rv", p0_rvalid, m_rv0);
            chk("m_p1_rv", p1_rvalid, m_rv1);
            chk("m_p0_rd", p0_rdata, m_rd0);
            chk("m_p1_rd", p1_rdata, m_rd1);
            w1 = p1_req && (!p0_req || denied >= SM);
            g0 = p0_req && !w1;
            ld = (w1 && p1_we) || (g0 && p0_we);
            chk("m_p0_gnt", p0_gnt, g0);
            chk("m_p1_gnt", p1_gnt, w1);
            chk("m_load", ram_load, ld);
            chk("m_addr", ram_address, w1 ? p1_addr : p0_addr);
            if (ld) chk("m_din", ram_data_in, w1 ? p1_wdata : p0_wdata);
            m_rv0 = g0 && !p0_we;
            m_rv1 = w1 && !p1_we;
            if (m_rv0) m_rd0 = ref_mem[p0_addr];
            if (m_rv1) m_rd1 = ref_mem[p1_addr];
            if (g0 && p0_we) ref_mem[p0_addr] = p0_wdata;
            if (w1 && p1_we) ref_mem[p1_addr] = p1_wdata;
            denied = (p1_req && !w1) ? denied + 1 : 0;
        end
    end

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic half(); @(negedge clk); endtask
    task automatic set0(input logic r, input logic w, input logic [13:0] a, input logic [15:0] d);
        p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
    endtask
    task automatic set1(input logic r, input logic w, input logic [13:0] a, input logic [15:0] d);
        p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
    endtask

    int          gk;
    logic        g_load, g_p0, seen;
    logic [13:0] g_addr;
    // holds port 1's request until granted (bounded), recording the grant cycle index
    task automatic wait_p1();
        gk = -1;
        for (int k = 0; k < 12 && gk < 0; k++) begin
            half();
            if (p1_gnt) begin gk = k; g_load = ram_load; g_addr = ram_address; g_p0 = p0_gnt; end
            nxt();
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
        rst_n = 0;
        set0(1, 1, 14'h10, 16'hffff);
        set1(0, 0, 0, 0);
        repeat (2) begin
            half();
            chk("reset_load", ram_load, 0);
            chk("reset_gnt", {p0_gnt, p1_gnt}, 0);
            nxt();
        end
        rst_n = 1;
        set0(0, 0, 0, 0);
        chk("reset_nowrite", mem[14'h10], 16'h0);
        set0(1, 1, 14'h0, 16'h1234); nxt();
        set0(1, 1, 14'h5, 16'h5678); nxt();
        set0(1, 0, 14'h5, 16'h0);
        half(); chk("p0_rd_gnt", p0_gnt, 1); nxt();
        set0(0, 0, 0, 0);
        half(); chk("p0_rvalid", p0_rvalid, 1); chk("p0_rdata", p0_rdata, 16'h5678); nxt();
        set1(1, 1, 14'd300, 16'habcd);
        half(); chk("p1_wr_gnt", p1_gnt, 1); nxt();
        set1(1, 0, 14'd300, 16'h0); nxt();
        set1(0, 0, 0, 0);
        half(); chk("p1_rdata", p1_rdata, 16'habcd); chk("p1_rvalid", p1_rvalid, 1); chk("p0_quiet", p0_rvalid, 0); nxt();
        set0(1, 0, 14'h5, 16'h0);
        set1(1, 1, 14'd450, 16'hdcba);
        wait_p1();
        set1(0, 0, 0, 0);
        chk("starve_lat", gk, SM);
        chk("starve_load", g_load, 1);
        chk("starve_addr", g_addr, 14'd450);
        chk("starve_p0", g_p0, 0);
        half(); chk("p0_resume", p0_gnt, 1); nxt();
        set0(0, 0, 0, 0);
        set1(1, 0, 14'd450, 16'h0); nxt();
        set1(0, 0, 0, 0);
        half(); chk("starve_rd", p1_rdata, 16'hdcba); nxt();
        set0(1, 1, 14'h70, 16'hdef0); nxt();
        set0(1, 0, 14'h70, 16'h0); nxt();
        set0(0, 0, 0, 0);
        half(); chk("raw_rdata", p0_rdata, 16'hdef0); nxt();
        set0(1, 0, 14'h5, 16'h0);
        set1(1, 1, 14'd62, 16'hbbbb);
        seen = 0;
        repeat (2) begin half(); seen = seen | p1_gnt; nxt(); end
        set1(0, 0, 0, 0);
        half(); seen = seen | p1_gnt; nxt();
        chk("withdraw_nognt", seen, 0);
        set1(1, 0, 14'd62, 16'h0);
        wait_p1();
        set1(0, 0, 0, 0);
        chk("withdraw_lat", gk, SM);
        half(); chk("withdraw_rv", p1_rvalid, 1); chk("withdraw_rd", p1_rdata, 16'h0); nxt();
        set0(0, 0, 0, 0);
        chk("withdraw_mem", mem[62], 16'h0);
        set0(1, 0, 14'h0, 16'h0); nxt();
        rst_n = 0;
        set0(0, 0, 0, 0);
        half(); chk("midrd_rv", p0_rvalid, 0); chk("midrd_rd", p0_rdata, 0); nxt();
        rst_n = 1;
        nxt(); nxt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ram16k_arbiter.md
# ram16k_arbiter

Two-requester arbiter that shares the single-port `ram16k` data memory between the CPU data port (port 0) and a secondary master such as a program loader or screen DMA engine (port 1). It sits directly in front of `ram16k` and drives its `load`/`address`/`data_in`. It performs one access per cycle and returns read data one cycle after grant. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress.

## Interface
- `ADDR_W`, 14: address width; matches `ram16k`.
- `DATA_W`, 16: data width.
- `STARVE_MAX`, 4: consecutive denied cycles after which port 1 wins one arbitration; legal range 1..15.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `p0_req`  in  1  port 0 access request; held until `p0_gnt`.
- `p0_we`  in  1  port 0 write enable (1 = write, 0 = read).
- `p0_addr`  in  ADDR_W  port 0 word address.
- `p0_wdata`  in  DATA_W  port 0 write data.
- `p0_gnt`  out  1  combinational grant; access is performed at this cycle's rising edge.
- `p0_rvalid`  out  1  registered; read data valid, one cycle after a read grant.
- `p0_rdata`  out  DATA_W  registered read data.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_gnt`, `p1_rvalid`, `p1_rdata`: same as port 0, for port 1.
- `ram_load`  out  1  to `ram16k.load`.
- `ram_address`  out  ADDR_W  to `ram16k.address`.
- `ram_data_in`  out  DATA_W  to `ram16k.data_in`.
- `ram_data_out`  in  DATA_W  from `ram16k.data_out`; combinational read of `ram_address`.

## Operation
- Internal state is limited to:
  - `wait_cnt`, a 4-bit saturating counter;
  - the per-port `rvalid`/`rdata` registers.
- Priority select, computed combinationally each cycle:
  - `sel1 = p1_req & (~p0_req | wait_cnt == STARVE_MAX)`.
  - `p0_gnt = p0_req & ~sel1`.
  - `p1_gnt = sel1`.
- RAM drive:
  - `ram_address`/`ram_data_in` come from port 1 when `sel1`, else from port 0. Port 0 values pass through even when idle.
  - `ram_load = (p0_gnt & p0_we) | (p1_gnt & p1_we)`.
  - `ram_load` is never 1 without a grant.
- `wait_cnt` update at each edge:
  - Clears to 0 when `p1_gnt` or `~p1_req`.
  - Otherwise increments, saturating at `STARVE_MAX`.
- Read return at each edge:
  - For the granted port with `we=0`: `rdata <= ram_data_out` and `rvalid <= 1`.
  - For every other port: `rvalid <= 0` and `rdata` holds.
- Writes produce no response and `rvalid` stays 0. The requester treats `gnt` as write completion.
- Read-after-write to the same address in the next cycle returns the new data, since the RAM updates at the write edge.
- At most one grant per cycle. `p0_gnt & p1_gnt` is never 1.
- Requester rule: `we`/`addr`/`wdata` stay stable while `req=1` and `gnt=0`. Dropping `req` before grant withdraws the request with no side effect.

## Timing
- Reset (asynchronous assert, synchronous release): `wait_cnt=0`, `p0_rvalid=p1_rvalid=0`, `p0_rdata=p1_rdata=0`.
- During reset, `ram_load` is forced to 0 and both grants are forced to 0.
- Reset asserted mid-read: the pending `rvalid` is lost. Requesters re-issue after release.
- Grant latency:
  - Port 0: 0 cycles, same cycle as `req`.
  - Port 1 when port 0 is idle: 0 cycles.
  - Port 1 under continuous port 0 traffic: granted on its (`STARVE_MAX`+1)th requesting cycle.
- Read latency: `rvalid`/`rdata` are valid exactly 1 cycle after the granted cycle, for one cycle only.
- Throughput: one access per cycle. Back-to-back reads from the same port give consecutive `rvalid` pulses.
- Starvation override: port 0 sees exactly one denied cycle. `wait_cnt` then returns to 0 and port 0 priority resumes.

## Test plan
- Reset: hold `rst_n=0` for 2 cycles with `p0_req=1`, `p0_we=1` → `ram_load=0`, both grants 0, `rvalid=0`, `rdata=0`. After release, memory at `p0_addr` is unchanged.
- Port 0 write then read:
  - Write 0x1234 @0x0000 and 0x5678 @0x0005.
  - Read 0x0005 → `p0_gnt` in the same cycle; the next cycle gives `p0_rvalid=1`, `p0_rdata=0x5678`.
- Idle-port-0 path: port 1 writes 0xabcd @300, then reads 300 → `p1_gnt` immediate, `p1_rdata=0xabcd` one cycle later, `p0_rvalid` stays 0.
- Contention and starvation (`STARVE_MAX=4`):
  - Port 0 issues continuous reads; port 1 requests a write of 0xdcba @450 from cycle t.
  - Required: `p1_gnt=1` only at cycle t+4, with `ram_load=1` and `ram_address=450`; `p0_gnt=0` at t+4 only.
  - A subsequent read of 450 returns 0xdcba.
- Read-after-write, same cycle pair: port 0 writes 0xdef0 @0x70 at cycle t and reads 0x70 at t+1 → `p0_rdata=0xdef0` at t+2.
- Withdrawn request: port 1 raises `req` with `we=1`, `wdata=0xbbbb` @62 under port 0 traffic, then drops `req` after 2 cycles → no grant, memory @62 unchanged, `wait_cnt` back to 0 (next starvation still takes the full 4 cycles).
